// File: rtl/cnn_seq_if.sv
// Handshake bundle between the CNN layer sequencer and the datapath that runs its stages.
// The master drives launch, abort, pool mask and stage-done strobes; the slave (the sequencer) drives enables and status.
interface cnn_seq_if #(
    parameter int NUM_LAYERS = 4,
    parameter int LW         = 4
);
    logic                  start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] pool_mask;
    logic                  conv_done;
    logic                  pool_done;
    logic                  gap_done;
    logic                  fc_done;
    logic                  conv_en;
    logic                  relu_en;
    logic                  pool_en;
    logic                  gap_en;
    logic                  fc_en;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [2:0]            err_stage;
    logic [LW-1:0]         layer_idx;
    logic [2:0]            debug_state;

    modport master (
        output start, abort, pool_mask, conv_done, pool_done, gap_done, fc_done,
        input  conv_en, relu_en, pool_en, gap_en, fc_en, busy, done, error,
               err_stage, layer_idx, debug_state
    );

    modport slave (
        input  start, abort, pool_mask, conv_done, pool_done, gap_done, fc_done,
        output conv_en, relu_en, pool_en, gap_en, fc_en, busy, done, error,
               err_stage, layer_idx, debug_state
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Sequences one CNN inference: per-layer conv(+relu) with optional pooling, then GAP, FC, DONE.
// A per-stage watchdog traps a stalled stage into ERR; abort or rst recovers.
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LW             = 4
) (
    input logic      clk,
    input logic      rst,
    cnn_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONV = 3'd1;
    localparam logic [2:0] S_POOL = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FC   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : {TW{1'b0}};
    localparam logic          WDOG_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [LW-1:0] L_LAST  = LW'(NUM_LAYERS - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_next_s;
    logic [LW-1:0]    layer_r;
    logic [LW-1:0]    layer_next_s;
    logic [TW-1:0]    timer_r;
    logic [TW-1:0]    timer_next_s;
    logic [2:0]       err_stage_r;
    logic [2:0]       err_stage_next_s;
    logic [7:0]       flags_r;
    logic             restart_s;
    logic             active_s;
    logic             stage_done_s;
    logic             timeout_s;
    logic             last_layer_s;
    logic             pool_sel_s;
    logic [(1<<LW)-1:0] mask_pad_s;

    // Output flag vector {conv,relu,pool,gap,fc,busy,done,error} for a given state code.
    function automatic logic [7:0] decode_flags(input logic [2:0] st);
        logic [7:0] v;
        case (st)
            S_CONV:  v = 8'b1100_0100;
            S_POOL:  v = 8'b0010_0100;
            S_GAP:   v = 8'b0001_0100;
            S_FC:    v = 8'b0000_1100;
            S_DONE:  v = 8'b0000_0010;
            S_ERR:   v = 8'b0000_0001;
            default: v = 8'b0000_0000;
        endcase
        return v;
    endfunction

    // Pool-mask lookup for the current layer and the done strobe owned by the current stage.
    always_comb begin
        mask_pad_s                   = '0;
        mask_pad_s[NUM_LAYERS-1:0]   = bus.pool_mask;
        pool_sel_s                   = mask_pad_s[layer_r];
        last_layer_s                 = (layer_r == L_LAST);
        active_s                     = (state_r >= S_CONV) && (state_r <= S_FC);
        case (state_r)
            S_CONV:  stage_done_s = bus.conv_done;
            S_POOL:  stage_done_s = bus.pool_done;
            S_GAP:   stage_done_s = bus.gap_done;
            S_FC:    stage_done_s = bus.fc_done;
            default: stage_done_s = 1'b0;
        endcase
        timeout_s = WDOG_EN && active_s && (timer_r == T_LAST) && !stage_done_s;
    end

    // Next-state, layer and error-stage logic; abort outranks every other input.
    always_comb begin
        state_next_s     = state_r;
        layer_next_s     = layer_r;
        err_stage_next_s = err_stage_r;
        restart_s        = 1'b0;
        if (bus.abort) begin
            state_next_s     = S_IDLE;
            layer_next_s     = {LW{1'b0}};
            err_stage_next_s = 3'd0;
        end else if (timeout_s) begin
            state_next_s     = S_ERR;
            err_stage_next_s = state_r;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_next_s = S_CONV;
                        layer_next_s = {LW{1'b0}};
                    end else begin
                        state_next_s = state_r;
                    end
                end
                S_CONV: begin
                    if (!bus.conv_done) begin
                        state_next_s = S_CONV;
                    end else if (pool_sel_s) begin
                        state_next_s = S_POOL;
                    end else if (!last_layer_s) begin
                        state_next_s = S_CONV;
                        layer_next_s = layer_r + LW'(1);
                        restart_s    = 1'b1;
                    end else begin
                        state_next_s = S_GAP;
                    end
                end
                S_POOL: begin
                    if (!bus.pool_done) begin
                        state_next_s = S_POOL;
                    end else if (!last_layer_s) begin
                        state_next_s = S_CONV;
                        layer_next_s = layer_r + LW'(1);
                    end else begin
                        state_next_s = S_GAP;
                    end
                end
                S_GAP: begin
                    if (bus.gap_done) state_next_s = S_FC;
                    else              state_next_s = S_GAP;
                end
                S_FC: begin
                    if (bus.fc_done) state_next_s = S_DONE;
                    else             state_next_s = S_FC;
                end
                S_ERR: begin
                    state_next_s = S_ERR;
                end
                default: begin
                    state_next_s     = S_IDLE;
                    layer_next_s     = {LW{1'b0}};
                    err_stage_next_s = 3'd0;
                end
            endcase
        end
    end

    // Watchdog restarts on every stage entry, including a CONV-to-CONV layer advance.
    always_comb begin
        if ((state_next_s != state_r) || restart_s) begin
            timer_next_s = {TW{1'b0}};
        end else if (active_s) begin
            timer_next_s = timer_r + TW'(1);
        end else begin
            timer_next_s = {TW{1'b0}};
        end
    end

    // State, counters and registered outputs; flags come from the next state so they track state_r exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            layer_r     <= {LW{1'b0}};
            timer_r     <= {TW{1'b0}};
            err_stage_r <= 3'd0;
            flags_r     <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            layer_r     <= layer_next_s;
            timer_r     <= timer_next_s;
            err_stage_r <= err_stage_next_s;
            flags_r     <= decode_flags(state_next_s);
        end
    end

    assign bus.conv_en     = flags_r[7];
    assign bus.relu_en     = flags_r[6];
    assign bus.pool_en     = flags_r[5];
    assign bus.gap_en      = flags_r[4];
    assign bus.fc_en       = flags_r[3];
    assign bus.busy        = flags_r[2];
    assign bus.done        = flags_r[1];
    assign bus.error       = flags_r[0];
    assign bus.err_stage   = err_stage_r;
    assign bus.layer_idx   = layer_r;
    assign bus.debug_state = state_r;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: directed scenarios with literal expectations, then random traffic
// compared every cycle against a stage-level behavioural model.
module tb_cnn_layer_sequencer;
    localparam int NL = 3;
    localparam int TO = 16;
    localparam int LW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cnn_seq_if #(.NUM_LAYERS(NL), .LW(LW)) bus ();

    cnn_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int layer;
        int cyc;
        int es;
    } model_t;

    model_t m = '{0, 0, 0, 0};
    int vectors     = 0;
    int miscompares = 0;

    // Advance the model one clock using the input values present at that edge.
    function automatic model_t next_model(model_t c, logic r, logic a, logic s, logic cd,
                                          logic pd, logic gd, logic fd, logic [NL-1:0] pm);
        model_t n = c;
        bit re = 1'b0;
        if (r || a) begin
            n = '{0, 0, 0, 0};
            return n;
        end
        case (c.st)
            0, 5: if (s) begin n.st = 1; n.layer = 0; end
            1: if (cd) begin
                   if (pm[c.layer])          n.st = 2;
                   else if (c.layer < NL-1) begin n.layer = c.layer + 1; re = 1'b1; end
                   else                      n.st = 3;
               end
            2: if (pd) begin
                   if (c.layer < NL-1) begin n.st = 1; n.layer = c.layer + 1; end
                   else                n.st = 3;
               end
            3: if (gd) n.st = 4;
            4: if (fd) n.st = 5;
            default: ;
        endcase
        if (c.st >= 1 && c.st <= 4 && n.st == c.st && !re && c.cyc == TO - 1) begin
            n.st = 6;
            n.es = c.st;
        end
        if (n.st != c.st || re)         n.cyc = 0;
        else if (n.st >= 1 && n.st <= 4) n.cyc = c.cyc + 1;
        else                             n.cyc = 0;
        return n;
    endfunction

    task automatic compare_model();
        logic [15:0] got;
        logic [15:0] exp;
        got = {bus.conv_en, bus.relu_en, bus.pool_en, bus.gap_en, bus.fc_en, bus.busy,
               bus.done, bus.error, bus.err_stage, bus.layer_idx, bus.debug_state};
        exp = {m.st == 1, m.st == 1, m.st == 2, m.st == 3, m.st == 4, (m.st >= 1 && m.st <= 4),
               m.st == 5, m.st == 6, 3'(m.es), LW'(m.layer), 3'(m.st)};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m = next_model(m, rst, bus.abort, bus.start, bus.conv_done, bus.pool_done,
                       bus.gap_done, bus.fc_done, bus.pool_mask);
        #1;
        compare_model();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.conv_done = 1'b0;
        bus.pool_done = 1'b0;
        bus.gap_done  = 1'b0;
        bus.fc_done   = 1'b0;
    endtask

    task automatic expect_st(input string name, input int st, input int layer);
        chk({name, "_state"}, 8'(bus.debug_state), 8'(st));
        chk({name, "_layer"}, 8'(bus.layer_idx), 8'(layer));
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.pool_mask = '0;
        bus.conv_done = 1'b0; bus.pool_done = 1'b0; bus.gap_done = 1'b0; bus.fc_done = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_flags", {bus.conv_en, bus.relu_en, bus.pool_en, bus.gap_en,
                            bus.fc_en, bus.busy, bus.done, bus.error}, 8'd0);
        expect_st("reset", 0, 0);

        // Three layers, pooling only after layer 1
        bus.pool_mask = 3'b010;
        bus.start = 1'b1;     tick(); expect_st("seq_conv0", 1, 0);
        chk("seq_conv0_en", {bus.conv_en, bus.relu_en}, 8'd3);
        bus.conv_done = 1'b1; tick(); expect_st("seq_conv1", 1, 1);
        bus.conv_done = 1'b1; tick(); expect_st("seq_pool1", 2, 1);
        bus.pool_done = 1'b1; tick(); expect_st("seq_conv2", 1, 2);
        bus.conv_done = 1'b1; tick(); expect_st("seq_gap", 3, 2);
        bus.gap_done = 1'b1;  tick(); expect_st("seq_fc", 4, 2);
        bus.fc_done = 1'b1;   tick(); expect_st("seq_done", 5, 2);
        chk("seq_done_flag", 8'(bus.done), 8'd1);
        tick(); chk("done_held", 8'(bus.done), 8'd1);

        // Restart from DONE, then stray start / fc_done in CONV, then abort beats conv_done
        bus.start = 1'b1;   tick(); expect_st("restart", 1, 0);
        bus.start = 1'b1;   tick(); expect_st("start_in_conv", 1, 0);
        bus.fc_done = 1'b1; tick(); expect_st("fc_in_conv", 1, 0);
        bus.abort = 1'b1; bus.conv_done = 1'b1; tick(); expect_st("abort_vs_done", 0, 0);

        // POOL stall: error appears on the 17th cycle after entry
        bus.start = 1'b1;     tick();
        bus.conv_done = 1'b1; tick();
        bus.conv_done = 1'b1; tick(); expect_st("wd_pool_entry", 2, 1);
        repeat (15) tick();
        chk("wd_cycle16_pool", {bus.pool_en, bus.error}, 8'd2);
        tick();
        chk("wd_error", 8'(bus.error), 8'd1);
        chk("wd_err_stage", 8'(bus.err_stage), 8'd2);
        chk("wd_pool_off", 8'(bus.pool_en), 8'd0);
        bus.start = 1'b1; tick(); expect_st("err_ignores_start", 6, 1);
        bus.abort = 1'b1; tick(); expect_st("err_abort", 0, 0);
        chk("err_cleared", {bus.error, 5'd0, bus.err_stage[1:0]}, 8'd0);

        // gap_done on the last watchdog cycle wins
        bus.pool_mask = 3'b000;
        bus.start = 1'b1; tick();
        repeat (3) begin bus.conv_done = 1'b1; tick(); end
        expect_st("edge_gap_entry", 3, 2);
        repeat (15) tick();
        bus.gap_done = 1'b1; tick();
        expect_st("edge_fc", 4, 2);
        chk("edge_no_error", 8'(bus.error), 8'd0);

        // rst in FC mid-inference
        rst = 1'b1; tick(); rst = 1'b0;
        expect_st("rst_fc", 0, 0);
        chk("rst_fc_flags", {bus.fc_en, bus.busy, bus.done, bus.error}, 8'd0);
        bus.start = 1'b1; tick(); expect_st("rst_restart", 1, 0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.abort     = ($urandom_range(0, 79) == 0);
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.conv_done = ($urandom_range(0, 7) == 0);
            bus.pool_done = ($urandom_range(0, 7) == 0);
            bus.gap_done  = ($urandom_range(0, 7) == 0);
            bus.fc_done   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) bus.pool_mask = NL'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 4, number of conv layers per inference (legal 1..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, max cycles allowed in one active stage; 0 disables the watchdog.
REQ-003 Parameter LW, default 4, width of layer_idx (>= clog2(NUM_LAYERS), min 1).
REQ-004 Ports: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch inference; honoured only in IDLE or DONE.
- abort  in  1  cancel operation / clear error.
- pool_mask  in  NUM_LAYERS  bit i=1: layer i is followed by pooling; sampled every cycle.
- conv_done  in  1  conv+relu of current layer complete (1-cycle pulse).
- pool_done  in  1  pooling of current layer complete.
- gap_done  in  1  global average pool complete.
- fc_done  in  1  fully connected stage complete.
- conv_en, relu_en, pool_en, gap_en, fc_en  out  1 each  stage enables.
- busy  out  1  high in CONV, POOL, GAP, FC.
- done  out  1  inference complete, held.
- error  out  1  watchdog fired, held.
- err_stage  out  3  state code of the stage that timed out.
- layer_idx  out  LW  current layer number.
- debug_state  out  3  current state code.

Function
REQ-005 States and codes: IDLE=0, CONV=1, POOL=2, GAP=3, FC=4, DONE=5, ERR=6; 7 unreachable and decodes to IDLE next cycle.
REQ-006 Outputs are Moore: all enables, busy, done, error and debug_state decode from the state register only.
REQ-007 Decode: CONV -> conv_en=relu_en=1; POOL -> pool_en=1; GAP -> gap_en=1; FC -> fc_en=1; DONE -> done=1; ERR -> error=1; all other enables 0.
REQ-008 IDLE: start=1 -> CONV, layer_idx<=0.
REQ-009 CONV: conv_done=1 -> POOL if pool_mask[layer_idx]=1; else -> CONV with layer_idx+1 if layer_idx<NUM_LAYERS-1; else -> GAP.
REQ-010 POOL: pool_done=1 -> CONV with layer_idx+1 if layer_idx<NUM_LAYERS-1, else -> GAP.
REQ-011 Layer-to-layer CONV->CONV re-enters CONV: timer restarts, conv_en stays continuously high.
REQ-012 GAP: gap_done=1 -> FC. FC: fc_done=1 -> DONE.
REQ-013 DONE: held until start=1 -> CONV, layer_idx<=0 (back-to-back inference, no IDLE cycle).
REQ-014 Done inputs not belonging to the current state are ignored.
REQ-015 start while busy or in ERR is ignored.
REQ-016 Watchdog timer: resets to 0 on every state entry (incl. CONV re-entry), increments each cycle in an active stage.
REQ-017 If TIMEOUT_CYCLES>0, timer==TIMEOUT_CYCLES-1, and the stage's done input is 0 -> ERR next cycle; err_stage<=current state code.
REQ-018 Stage done in the same cycle as timeout expiry wins; no error.
REQ-019 ERR: held; start ignored; only abort or rst leaves ERR.
REQ-020 abort=1 in any state except IDLE -> IDLE next cycle; layer_idx<=0, err_stage<=0.
REQ-021 abort has priority over start, done inputs and timeout.
REQ-022 layer_idx holds its value in GAP, FC, DONE and ERR; never exceeds NUM_LAYERS-1.

Reset
REQ-023 rst=1 at a clock edge -> state=IDLE, layer_idx=0, timer=0, err_stage=0; all outputs 0 the following cycle.
REQ-024 rst has priority over abort, start and all done inputs, including mid-inference.

Verification
REQ-025 NUM_LAYERS=3, pool_mask=3'b010, prompt dones -> CONV(L0), CONV(L1), POOL(L1), CONV(L2), GAP, FC, DONE; done=1, layer_idx=2.
REQ-026 TIMEOUT_CYCLES=16, no pool_done in POOL -> error=1 on the 17th cycle after POOL entry, err_stage=2, pool_en=0; abort -> IDLE, error=0.
REQ-027 TIMEOUT_CYCLES=16, gap_done exactly in the 16th GAP cycle -> FC entered, error stays 0.
REQ-028 rst pulsed in FC with layer_idx=2 -> next cycle IDLE, all outputs 0, layer_idx=0; later start -> CONV with layer_idx=0.
REQ-029 start in DONE -> CONV with layer_idx=0 next cycle; start during CONV -> no effect; fc_done during CONV -> no effect.
REQ-030 abort and conv_done in the same CONV cycle -> IDLE, not CONV/POOL.
